// File: rtl/integer_alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// integer_alu_arbiter_pkg
//   Shared types, constants and helpers for the integer_alu_arbiter slice.
//   - arb_state_t : issue FSM states
//   - NUM_REQ_MAX : largest supported requester count
//   - TAG_W       : width of a requester index (tag) sized for NUM_REQ_MAX
//   - rr_pick()   : round-robin selection of the first valid index at or
//                   after a pointer, wrapping at n
// -----------------------------------------------------------------------------
package integer_alu_arbiter_pkg;

    localparam int unsigned NUM_REQ_MAX = 8;
    localparam int unsigned TAG_W       = $clog2(NUM_REQ_MAX);

    typedef enum logic {
        IDLE,
        ISSUE
    } arb_state_t;

    // Returns the first index i (searching ptr, ptr+1, ... mod n) with valid[i]=1.
    // Returns 0 when nothing is valid; callers gate on |valid.
    function automatic logic [TAG_W-1:0] rr_pick(
        input logic [NUM_REQ_MAX-1:0] valid,
        input logic [TAG_W-1:0]       ptr,
        input int unsigned            n
    );
        logic [TAG_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ_MAX; off++) begin
            idx = (32'(ptr) + off) % n;
            if ((off < n) && !found && valid[idx[TAG_W-1:0]]) begin
                pick  = idx[TAG_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/integer_alu_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// integer_alu_arb_tag_fifo
//   Synchronous FIFO holding the requester tag of every operation issued to the
//   ALU and not yet answered. Count-based full/empty; a simultaneous push and
//   pop leaves the count unchanged. Pushes while full and pops while empty are
//   ignored.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push_i/data_i write request and tag
//   pop_i         remove the head entry
//   full_o        DEPTH entries stored
//   empty_o       no entries stored
//   head_o        tag at the head (valid when !empty_o)
// -----------------------------------------------------------------------------
module integer_alu_arb_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind the count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/integer_alu_arbiter.sv
// -----------------------------------------------------------------------------
// integer_alu_arbiter
//   Shares one integer_alu kernel among NUM_REQ requesters. A round-robin
//   grant latches one request (in1, in2, op), issues one beat on each ALU input
//   AXIS port and records the requester index in a tag FIFO. Each ALU result
//   is routed combinationally to the requester at the FIFO head.
// Ports:
//   ap_clk, ap_rst            clock, asynchronous active-high reset
//   req_valid/req_ready       per-requester request handshake (ready one-hot)
//   req_in1/req_in2/req_op    packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready       per-requester result handshake (valid one-hot)
//   rsp_data                  result data, broadcast
//   in1_T*/in2_T*/op_T*       ALU operand/op AXIS masters
//   out_r_T*                  ALU result AXIS slave
//   wdog_timeout              sticky no-progress flag
// Configuration:
//   ALU_ARB_WATCHDOG_EN       when defined, wdog_timeout sets after
//                             WDOG_CYCLES busy cycles without any ALU AXIS
//                             handshake; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module integer_alu_arbiter
    import integer_alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned OP_W        = 8,
    parameter int unsigned TAG_DEPTH   = 4,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in2,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]         in1_TDATA,
    output logic                      in1_TVALID,
    input  logic                      in1_TREADY,
    output logic [DATA_W-1:0]         in2_TDATA,
    output logic                      in2_TVALID,
    input  logic                      in2_TREADY,
    output logic [OP_W-1:0]           op_TDATA,
    output logic                      op_TVALID,
    input  logic                      op_TREADY,
    input  logic [DATA_W-1:0]         out_r_TDATA,
    input  logic                      out_r_TVALID,
    output logic                      out_r_TREADY,
    output logic                      wdog_timeout
);

    arb_state_t         state_q, state_d;
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  in1_q, in1_d;
    logic [DATA_W-1:0]  in2_q, in2_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               in1_vld_q, in1_vld_d;
    logic               in2_vld_q, in2_vld_d;
    logic               op_vld_q, op_vld_d;

    logic [NUM_REQ_MAX-1:0] valid_ext;
    logic [TAG_W-1:0]       grant;
    logic                   grant_en;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [TAG_W-1:0]       head_tag;
    logic [NUM_REQ-1:0]     rsp_ready_sh;
    logic                   res_hs;

    assign valid_ext = NUM_REQ_MAX'(req_valid);
    assign grant     = rr_pick(valid_ext, rr_ptr_q, NUM_REQ);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        op_d      = op_q;
        in1_vld_d = in1_vld_q;
        in2_vld_d = in2_vld_q;
        op_vld_d  = op_vld_q;
        grant_en  = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                // Only the full flag gates a grant; a same-cycle pop does not help.
                if ((|req_valid) && !fifo_full) begin
                    grant_en  = 1'b1;
                    req_ready = NUM_REQ'(1) << grant;
                    in1_d     = req_in1[grant*DATA_W +: DATA_W];
                    in2_d     = req_in2[grant*DATA_W +: DATA_W];
                    op_d      = req_op[grant*OP_W +: OP_W];
                    rr_ptr_d  = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    in1_vld_d = 1'b1;
                    in2_vld_d = 1'b1;
                    op_vld_d  = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // The registered TVALID doubles as the per-port "not yet sent" flag.
                in1_vld_d = in1_vld_q & ~in1_TREADY;
                in2_vld_d = in2_vld_q & ~in2_TREADY;
                op_vld_d  = op_vld_q  & ~op_TREADY;
                if (!in1_vld_d && !in2_vld_d && !op_vld_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            op_q      <= '0;
            in1_vld_q <= 1'b0;
            in2_vld_q <= 1'b0;
            op_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            op_q      <= op_d;
            in1_vld_q <= in1_vld_d;
            in2_vld_q <= in2_vld_d;
            op_vld_q  <= op_vld_d;
        end
    end

    assign in1_TDATA  = in1_q;
    assign in2_TDATA  = in2_q;
    assign op_TDATA   = op_q;
    assign in1_TVALID = in1_vld_q;
    assign in2_TVALID = in2_vld_q;
    assign op_TVALID  = op_vld_q;

    integer_alu_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk_i   (ap_clk),
        .rst_i   (ap_rst),
        .push_i  (grant_en),
        .data_i  (grant),
        .pop_i   (res_hs),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_tag)
    );

    // Result return path: zero latency, steered by the head tag.
    assign rsp_ready_sh = rsp_ready >> head_tag;
    assign out_r_TREADY = !fifo_empty && rsp_ready_sh[0];
    assign rsp_valid    = (out_r_TVALID && !fifo_empty) ? (NUM_REQ'(1) << head_tag) : '0;
    assign rsp_data     = out_r_TDATA;
    assign res_hs       = out_r_TVALID & out_r_TREADY;

`ifdef ALU_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic            wdog_q;
    logic            axis_hs;

    assign axis_hs = (in1_TVALID & in1_TREADY) | (in2_TVALID & in2_TREADY) |
                     (op_TVALID & op_TREADY) | res_hs;

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (axis_hs) begin
            wdog_cnt_d = '0;
        end else if ((!fifo_empty || (state_q == ISSUE)) &&
                     (wdog_cnt_q != WD_W'(WDOG_CYCLES))) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wdog_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_q     <= wdog_q | (wdog_cnt_d == WD_W'(WDOG_CYCLES));
        end
    end

    assign wdog_timeout = wdog_q;
`else
    assign wdog_timeout = 1'b0;
`endif

endmodule
